// File: rtl/uart_host_rx.sv
// Host-side 8N1 UART receiver: synchronises rxd, samples bits at mid-period,
// checks the stop bit and queues bytes in a small FIFO behind a valid/ready port.
module uart_host_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_err,
    output logic       busy
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Input synchroniser; presets to the idle level so reset never looks like a start bit
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign rx_s = sync_reg[1];

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         bit_reg, bit_next;
    logic [7:0]         shift_reg, shift_next;
    logic               push;
    logic               frame_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push       = 1'b0;
        frame_set  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch
                if (cnt_reg == CNT_W'(HALF - 1)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_W'(DIV - 1)) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_reg == CNT_W'(DIV - 1)) begin
                    cnt_next   = '0;
                    push       = 1'b1;
                    frame_set  = !rx_s;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Byte FIFO with an extra pointer bit to tell full from empty
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [7:0]    data_reg;
    logic [7:0]    head_next;
    logic          empty, full, pop, push_ok, ovf_set;
    logic          frame_err_reg, overflow_reg;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop     = !empty && ready;
    // A pop in the same cycle frees the slot the incoming byte needs
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    // The new head bypasses the RAM when it is the byte being written this cycle
    assign head_next = (push_ok && (rd_ptr_next == wr_ptr_reg)) ? shift_reg
                                                                : mem[rd_ptr_next[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            data_reg      <= '0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (wr_ptr_next != rd_ptr_next) begin
                data_reg <= head_next;
            end
            if (frame_set) begin
                frame_err_reg <= 1'b1;
            end else if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign data      = data_reg;
    assign valid     = !empty;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule
